pc_unit: RTL

Parametrised program-counter unit for the 2A03/6502 core. It is the successor to the fixed 16-bit PC. It supports:
- increment
- byte-wise loads from either the ALU or the memory bus
- a two-cycle relative-branch sequencer that reproduces the 6502 page-cross penalty

It sits between the control unit, the ALU and the address mux. It drives the fetch address, and it drives busy so the control unit can stall.

---
 rtl/pc_unit_if.sv | 31 +++
 rtl/pc_unit.sv | 85 ++++++++
 2 files changed

// File: rtl/pc_unit_if.sv
// pc_unit_if -- command/result bundle between the control unit and pc_unit.
//   master : control side; drives inc/load_l/load_h/src_sel/alu_in/mem_in/
//            branch/offset and observes pc/pc_l/pc_h/busy/page_cross.
//   slave  : pc_unit side; the mirror image of master.
interface pc_unit_if #(
  parameter int WIDTH = 16
);
  logic             inc;
  logic             load_l;
  logic             load_h;
  logic             src_sel;
  logic [7:0]       alu_in;
  logic [7:0]       mem_in;
  logic             branch;
  logic [7:0]       offset;
  logic [WIDTH-1:0] pc;
  logic [7:0]       pc_l;
  logic [WIDTH-9:0] pc_h;
  logic             busy;
  logic             page_cross;

  modport master (
    output inc, load_l, load_h, src_sel, alu_in, mem_in, branch, offset,
    input  pc, pc_l, pc_h, busy, page_cross
  );

  modport slave (
    input  inc, load_l, load_h, src_sel, alu_in, mem_in, branch, offset,
    output pc, pc_l, pc_h, busy, page_cross
  );
endinterface

// File: rtl/pc_unit.sv
// pc_unit -- program counter for the 2A03/6502 core.
//   Increments, loads low/high parts from the ALU or memory bus, and runs a
//   two-cycle relative branch that adds one extra cycle when the branch
//   target lies on a different page.
// Ports:
//   clk   : clock, all state updates on the rising edge
//   rst_n : asynchronous active-low reset (pc <= RESET_VAL, IDLE)
//   bus   : pc_unit_if.slave -- commands in; pc, pc_l, pc_h, busy,
//           page_cross out (all straight from registers)
module pc_unit #(
  parameter int          WIDTH     = 16,
  parameter logic [23:0] RESET_VAL = 24'h000000
) (
  input  logic        clk,
  input  logic        rst_n,
  pc_unit_if.slave    bus
);

  localparam int HW = WIDTH - 8;

  typedef enum logic {IDLE, FIX} state_t;

  state_t         state_q;
  logic [WIDTH-1:0] pc_q;
  logic           busy_q;
  logic           page_cross_q;
  logic           adj_dn_q;     // direction of the pending high-part fix

  logic [8:0]     br_sum;
  logic           br_cross;
  logic [7:0]     load_byte;
  logic [HW+7:0]  load_ext;     // zero-extended byte, wide enough for any HW

  assign br_sum    = {1'b0, pc_q[7:0]} + {1'b0, bus.offset};
  // Carry out of a positive offset or missing carry on a negative offset
  // means the target is on the neighbouring page.
  assign br_cross  = br_sum[8] ^ bus.offset[7];
  assign load_byte = bus.src_sel ? bus.mem_in : bus.alu_in;
  assign load_ext  = {{HW{1'b0}}, load_byte};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      pc_q         <= RESET_VAL[WIDTH-1:0];
      busy_q       <= 1'b0;
      page_cross_q <= 1'b0;
      adj_dn_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.branch) begin
            pc_q[7:0] <= br_sum[7:0];
            if (br_cross) begin
              state_q      <= FIX;
              busy_q       <= 1'b1;
              page_cross_q <= 1'b1;
              adj_dn_q     <= bus.offset[7];
            end
          end else if (bus.load_l || bus.load_h) begin
            if (bus.load_l) pc_q[7:0]       <= load_byte;
            if (bus.load_h) pc_q[WIDTH-1:8] <= load_ext[HW-1:0];
          end else if (bus.inc) begin
            pc_q <= pc_q + WIDTH'(1);
          end
        end
        FIX: begin
          // All commands are dropped here; only the high part moves.
          if (adj_dn_q) pc_q[WIDTH-1:8] <= pc_q[WIDTH-1:8] - HW'(1);
          else          pc_q[WIDTH-1:8] <= pc_q[WIDTH-1:8] + HW'(1);
          state_q      <= IDLE;
          busy_q       <= 1'b0;
          page_cross_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.pc         = pc_q;
  assign bus.pc_l       = pc_q[7:0];
  assign bus.pc_h       = pc_q[WIDTH-1:8];
  assign bus.busy       = busy_q;
  assign bus.page_cross = page_cross_q;

endmodule
